// File: rtl/backtrack_engine.sv
// backtrack_engine
//
// Consumer end of the decision_engine handshake in the hardware BCP solver.
// Every decision is pushed onto a chronological decision stack. On a BCP
// conflict the engine undoes decisions chronologically:
//   - already-flipped levels are popped, one per cycle, and reported as unassigned;
//   - the most recent unflipped decision is flipped and driven back to BCP.
// A conflict that finds the stack empty means the formula is UNSAT.
//
// Ports:
//   clock            rising-edge clock
//   reset            synchronous, active-high reset
//   decision_finish  1-cycle strobe: push {var_in, assignment_in}
//   var_in           one-hot decided variable (stored verbatim)
//   assignment_in    decided value
//   conflict         1-cycle strobe: BCP found a conflict, start backtrack
//   var_out          one-hot variable whose value was flipped (held)
//   assignment_out   new (flipped) value for var_out (held)
//   backtrack_finish 1-cycle pulse: backtrack complete (flip done or UNSAT)
//   unassign_valid   1-cycle pulse per popped level
//   unassign_var     one-hot variable being unassigned
//   unsat            sticky: conflict with no unflipped level left
//   overflow         sticky: push attempted while stack full
//   depth            current number of stack entries
`timescale 1ns/1ps

module backtrack_engine #(
  parameter int var_num       = 8,
  parameter int address_width = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     decision_finish,
  input  logic [var_num-1:0]       var_in,
  input  logic                     assignment_in,
  input  logic                     conflict,
  output logic [var_num-1:0]       var_out,
  output logic                     assignment_out,
  output logic                     backtrack_finish,
  output logic                     unassign_valid,
  output logic [var_num-1:0]       unassign_var,
  output logic                     unsat,
  output logic                     overflow,
  output logic [address_width:0]   depth
);

  localparam int stack_depth = 2 ** address_width;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    UNSAT = 2'd2
  } state_t;

  state_t state, state_next;

  // Stack storage, kept as three parallel arrays (variable, value, flipped bit).
  logic [var_num-1:0] stack_var     [stack_depth];
  logic               stack_value   [stack_depth];
  logic               stack_flipped [stack_depth];

  // A full stack has only the extra MSB of depth set.
  localparam logic [address_width:0] full_depth = {1'b1, {address_width{1'b0}}};

  logic [address_width:0]   depth_m1;
  logic [address_width-1:0] top_idx;
  logic [address_width-1:0] push_idx;
  logic [var_num-1:0]       top_var;
  logic                     top_value;
  logic                     top_flipped;

  assign depth_m1    = depth - 1'b1;
  assign top_idx     = depth_m1[address_width-1:0];
  assign push_idx    = depth[address_width-1:0];
  assign top_var     = stack_var[top_idx];
  assign top_value   = stack_value[top_idx];
  assign top_flipped = stack_flipped[top_idx];

  // The conflict strobe is registered for one cycle before SCAN starts, so the
  // first stack inspection happens two edges after the conflict is sampled.
  logic conflict_pending, conflict_pending_next;

  logic                   push_en, flip_en;
  logic [address_width:0] depth_next;
  logic [var_num-1:0]     var_out_next, unassign_var_next;
  logic                   assignment_out_next, finish_next, unassign_valid_next;
  logic                   unsat_next, overflow_next;

  // Next-state and registered-output logic. Conflict has priority over a
  // simultaneous decision_finish, which is simply dropped.
  always_comb begin
    state_next            = state;
    conflict_pending_next = 1'b0;
    push_en               = 1'b0;
    flip_en               = 1'b0;
    depth_next            = depth;
    var_out_next          = var_out;
    assignment_out_next   = assignment_out;
    finish_next           = 1'b0;
    unassign_valid_next   = 1'b0;
    unassign_var_next     = unassign_var;
    unsat_next            = unsat;
    overflow_next         = overflow;

    unique case (state)
      IDLE: begin
        if (conflict_pending) begin
          state_next = SCAN;
        end else if (conflict) begin
          conflict_pending_next = 1'b1;
        end else if (decision_finish) begin
          if (depth == full_depth) begin
            overflow_next = 1'b1;
          end else begin
            push_en    = 1'b1;
            depth_next = depth + 1'b1;
          end
        end
      end

      SCAN: begin
        if (depth == '0) begin
          unsat_next  = 1'b1;
          finish_next = 1'b1;
          state_next  = UNSAT;
        end else if (top_flipped) begin
          depth_next          = depth_m1;
          unassign_valid_next = 1'b1;
          unassign_var_next   = top_var;
        end else begin
          flip_en             = 1'b1;
          var_out_next        = top_var;
          assignment_out_next = ~top_value;
          finish_next         = 1'b1;
          state_next          = IDLE;
        end
      end

      UNSAT: begin
        state_next = UNSAT;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      conflict_pending <= 1'b0;
      depth            <= '0;
      var_out          <= '0;
      assignment_out   <= 1'b0;
      backtrack_finish <= 1'b0;
      unassign_valid   <= 1'b0;
      unassign_var     <= '0;
      unsat            <= 1'b0;
      overflow         <= 1'b0;
    end else begin
      state            <= state_next;
      conflict_pending <= conflict_pending_next;
      depth            <= depth_next;
      var_out          <= var_out_next;
      assignment_out   <= assignment_out_next;
      backtrack_finish <= finish_next;
      unassign_valid   <= unassign_valid_next;
      unassign_var     <= unassign_var_next;
      unsat            <= unsat_next;
      overflow         <= overflow_next;
    end
  end

  // Stack contents carry no reset; reset only blocks writes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (push_en) begin
        stack_var[push_idx]     <= var_in;
        stack_value[push_idx]   <= assignment_in;
        stack_flipped[push_idx] <= 1'b0;
      end
      if (flip_en) begin
        stack_value[top_idx]   <= ~top_value;
        stack_flipped[top_idx] <= 1'b1;
      end
    end
  end

endmodule
